// File: rtl/div_share_arbiter.sv
// Shares one iterative divider between two requesters: arbitrates, holds operands, returns results.
// Optional build macro DIV_ZERO_BYPASS_EN answers divide-by-zero locally without starting the divider.
module div_share_arbiter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [1:0]     req_usigned,
  input  logic [2*W-1:0] req_divisor,
  input  logic [2*W-1:0] req_dividend,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_quotient,
  output logic [W-1:0]   rsp_reminder,
  output logic           busy,
  output logic           div_valid,
  output logic           div_usigned,
  output logic [W-1:0]   div_divisor,
  output logic [W-1:0]   div_dividend,
  input  logic [W-1:0]   div_quotient,
  input  logic [W-1:0]   div_reminder,
  input  logic           div_res_ready,
  output logic           div_rst_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         owner_q, owner_d;
  logic         last_grant_q, last_grant_d;
  logic         us_q, us_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W-1:0] dvd_q, dvd_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic         rst_n_q, rst_n_d;

  logic         grant;
  logic         accept;
  logic         sel_us;
  logic [W-1:0] sel_dvs;
  logic [W-1:0] sel_dvd;

  // A lone requester always wins; on a tie the port that did not win last time goes first.
  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = (state_q == IDLE) && req_valid[gi] && (grant == 1'(gi));
      assign rsp_valid[gi] = (state_q == RESP) && (owner_q == 1'(gi));
    end
  endgenerate

  assign accept  = |(req_valid & req_ready);
  assign sel_us  = grant ? req_usigned[1] : req_usigned[0];
  assign sel_dvs = grant ? req_divisor[2*W-1:W]  : req_divisor[W-1:0];
  assign sel_dvd = grant ? req_dividend[2*W-1:W] : req_dividend[W-1:0];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    us_d         = us_q;
    dvs_d        = dvs_q;
    dvd_d        = dvd_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    rst_n_d      = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = grant;
          last_grant_d = grant;
          us_d         = sel_us;
          dvs_d        = sel_dvs;
          dvd_d        = sel_dvd;
`ifdef DIV_ZERO_BYPASS_EN
          if (sel_dvs == '0) begin
            quo_d   = '1;
            rem_d   = sel_dvd;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      // Operands are left untouched here: the divider keeps sampling them until done.
      WAIT: begin
        if (div_res_ready) begin
          quo_d   = div_quotient;
          rem_d   = div_reminder;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      us_q         <= 1'b0;
      dvs_q        <= '0;
      dvd_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      us_q         <= us_d;
      dvs_q        <= dvs_d;
      dvd_q        <= dvd_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
    end
  end

  // Held low through the first edge after release so the divider's synchronous reset is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_n_q <= 1'b0;
    end else begin
      rst_n_q <= rst_n_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign div_valid    = (state_q == ISSUE);
  assign div_usigned  = us_q;
  assign div_divisor  = dvs_q;
  assign div_dividend = dvd_q;
  assign rsp_quotient = quo_q;
  assign rsp_reminder = rem_q;
  assign div_rst_n    = rst_n_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter: directed scenarios plus randomized traffic,
// with a behavioural divider and a reference model of arbitration, latency and results.
module tb_div_share_arbiter;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [1:0]     req_usigned;
  logic [2*W-1:0] req_divisor;
  logic [2*W-1:0] req_dividend;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_quotient;
  logic [W-1:0]   rsp_reminder;
  logic           busy;
  logic           div_valid;
  logic           div_usigned;
  logic [W-1:0]   div_divisor;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_quotient = '0;
  logic [W-1:0]   div_reminder = '0;
  logic           div_res_ready = 1'b0;
  logic           div_rst_n;

  int checks = 0;
  int passed = 0;
  int lat = 1;
  logic last_grant_m = 1'b1;
  logic         op_us  [2];
  logic [W-1:0] op_dvd [2];
  logic [W-1:0] op_dvs [2];

  div_share_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_usigned(req_usigned),
    .req_divisor(req_divisor), .req_dividend(req_dividend),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_reminder(rsp_reminder),
    .busy(busy), .div_valid(div_valid), .div_usigned(div_usigned),
    .div_divisor(div_divisor), .div_dividend(div_dividend),
    .div_quotient(div_quotient), .div_reminder(div_reminder),
    .div_res_ready(div_res_ready), .div_rst_n(div_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic us, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (us) begin
      q = a / b;
      r = a % b;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {q, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Behavioural divider: samples operands on the start pulse, answers after 'lat' cycles,
  // and drives junk on the result bus whenever it is not signalling done.
  int dcnt = 0;
  logic         d_us;
  logic [W-1:0] d_dvd, d_dvs;
  always @(negedge clk) begin
    logic [63:0] qr;
    div_res_ready = 1'b0;
    div_quotient  = $urandom;
    div_reminder  = $urandom;
    if (rst || !div_rst_n) begin
      dcnt = 0;
    end else if (div_valid) begin
      dcnt  = lat;
      d_us  = div_usigned;
      d_dvd = div_dividend;
      d_dvs = div_divisor;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        qr = ref_div(d_us, d_dvd, d_dvs);
        div_quotient  = qr[63:32];
        div_reminder  = qr[31:0];
        div_res_ready = 1'b1;
      end
    end
  end

  task automatic serve(input logic [1:0] mask, input int hold);
    logic [1:0] pend;
    int w, cyc;
    logic bypass, held, rr_bad, dv_bad;
    logic [63:0] exp_qr;
    logic [31:0] q0, r0;
    pend = mask;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      req_usigned[p]         = op_us[p];
      req_divisor[p*W +: W]  = op_dvs[p];
      req_dividend[p*W +: W] = op_dvd[p];
    end
    req_valid = pend;
    #1;
    while (pend != 2'b00) begin
      w = (pend == 2'b11) ? (last_grant_m ? 0 : 1) : (pend[1] ? 1 : 0);
      cyc = 0;
      while (req_ready == 2'b00 && cyc < 50) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      chk("grant", req_ready, 2'b01 << w);
      if (req_ready != (2'b01 << w)) begin
        req_valid = 2'b00;
        return;
      end
      last_grant_m = w[0];
      bypass = (op_dvs[w] == 32'd0);
      exp_qr = ref_div(op_us[w], op_dvd[w], op_dvs[w]);
      @(posedge clk);
      #1;
      pend[w] = 1'b0;
      req_valid = pend;
      chk("div_valid_issue", div_valid, !bypass);
      chk("busy_after_accept", busy, 1);
      if (!bypass) begin
        chk("div_operands", {div_dividend, div_divisor}, {op_dvd[w], op_dvs[w]});
        chk("div_usigned", div_usigned, op_us[w]);
      end
      cyc = 0;
      held = 1'b1;
      rr_bad = 1'b0;
      dv_bad = 1'b0;
      while (rsp_valid == 2'b00 && cyc < 200) begin
        if (req_ready != 2'b00) rr_bad = 1'b1;
        if ({div_usigned, div_dividend, div_divisor} !== {op_us[w], op_dvd[w], op_dvs[w]}) held = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (div_valid) dv_bad = 1'b1;
      end
      chk("latency", cyc, bypass ? 0 : lat + 1);
      chk("div_valid_single", dv_bad, 0);
      chk("operands_held", held, 1);
      chk("rsp_valid", rsp_valid, 2'b01 << w);
      chk("quotient", rsp_quotient, exp_qr[63:32]);
      chk("reminder", rsp_reminder, exp_qr[31:0]);
      q0 = rsp_quotient;
      r0 = rsp_reminder;
      rsp_ready = ~(2'b01 << w);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (rsp_valid != (2'b01 << w) || rsp_quotient !== q0 || rsp_reminder !== r0) held = 1'b0;
        if (req_ready != 2'b00) rr_bad = 1'b1;
      end
      if (hold > 0) chk("rsp_hold_stable", held, 1);
      rsp_ready = 2'b01 << w;
      #1;
      if (req_ready != 2'b00) rr_bad = 1'b1;
      chk("req_ready_blocked", rr_bad, 0);
      @(posedge clk);
      #1;
      rsp_ready = 2'b00;
      chk("rsp_done", {busy, rsp_valid}, 0);
      $display("txn port=%0d us=%0d %h / %h -> q=%h r=%h lat=%0d hold=%0d",
               w, op_us[w], op_dvd[w], op_dvs[w], q0, r0, lat, hold);
    end
  endtask

  initial begin
    int cyc;
    logic bad;
    rst = 1'b1;
    req_valid = 2'b00;
    req_usigned = 2'b00;
    req_divisor = '0;
    req_dividend = '0;
    rsp_ready = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_quotient, rsp_reminder}, 0);
    chk("rst_busy_divvalid", {busy, div_valid, div_usigned}, 0);
    chk("rst_div_operands", {div_dividend, div_divisor}, 0);
    chk("rst_div_rst_n", div_rst_n, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_div_rst_n_low", div_rst_n, 0);
    @(posedge clk);
    #1;
    chk("release_div_rst_n_high", div_rst_n, 1);

    // Tie right after reset: port 0 first, then port 1; a second tie grants port 0 again.
    lat = 3;
    op_us[0] = 1'b1; op_dvd[0] = 32'd20; op_dvs[0] = 32'd3;
    op_us[1] = 1'b1; op_dvd[1] = 32'd9;  op_dvs[1] = 32'd4;
    serve(2'b11, 0);
    lat = 5;
    serve(2'b11, 10);

    // Single unsigned request.
    lat = 4;
    op_us[0] = 1'b1; op_dvd[0] = 32'd100; op_dvs[0] = 32'd7;
    serve(2'b01, 2);

    // Signed request on port 1.
    lat = 6;
    op_us[1] = 1'b0; op_dvd[1] = 32'hFFFF_FFF9; op_dvs[1] = 32'd2;
    serve(2'b10, 1);

    // Reset while waiting on the divider.
    lat = 40;
    @(negedge clk);
    req_usigned[0] = 1'b1;
    req_dividend[W-1:0] = 32'd1000;
    req_divisor[W-1:0] = 32'd9;
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("rstwait_issue", div_valid, 1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstwait_busy", busy, 0);
    chk("rstwait_rsp_valid", rsp_valid, 0);
    chk("rstwait_div_rst_n", div_rst_n, 0);
    last_grant_m = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstwait_release_low", div_rst_n, 0);
    @(posedge clk);
    #1;
    chk("rstwait_release_high", div_rst_n, 1);
    bad = 1'b0;
    for (cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk);
      #1;
      if (rsp_valid != 2'b00 || busy) bad = 1'b1;
    end
    chk("rstwait_no_response", bad, 0);
    lat = 2;
    op_us[0] = 1'b1; op_dvd[0] = 32'd1000; op_dvs[0] = 32'd9;
    serve(2'b01, 0);

`ifdef DIV_ZERO_BYPASS_EN
    op_us[0] = 1'b1; op_dvd[0] = 32'h1234; op_dvs[0] = 32'd0;
    serve(2'b01, 1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 20; n++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        op_us[p]  = 1'($urandom_range(0, 1));
        op_dvd[p] = $urandom;
        op_dvs[p] = $urandom >> $urandom_range(0, 31);
        if (op_dvs[p] == 32'd0) op_dvs[p] = 32'd1;
        if (!op_us[p] && op_dvs[p] == 32'hFFFF_FFFF && op_dvd[p] == 32'h8000_0000) op_dvd[p] = 32'd1;
      end
      lat = $urandom_range(1, 8);
      serve(mask, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Two-port front end that shares one iterative divider datapath between two requesters. It registers the winning request's operands and holds them stable for the whole division, then sequences the divider's start/done handshake. It returns quotient and remainder to the owning requester through a valid/ready response port. The block sits between two issue ports, for example a pair of execution lanes, and the single divider instance.

## Interface
Parameters:
- `W`, default 32: operand/result width; must match the divider's `parallelism`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  request valid per port (bit i = port i).
- `req_ready`  out  2  request accepted this cycle when `req_valid[i] & req_ready[i]`.
- `req_usigned`  in  2  per-port unsigned-mode flag.
- `req_divisor`  in  2*W  port i operands in bits `[i*W +: W]`.
- `req_dividend`  in  2*W  port i operands in bits `[i*W +: W]`.
- `rsp_valid`  out  2  result valid for port i; at most one bit set.
- `rsp_ready`  in  2  per-port result accept.
- `rsp_quotient`  out  W  shared result bus, meaningful only while a `rsp_valid` bit is set.
- `rsp_reminder`  out  W  shared result bus, meaningful only while a `rsp_valid` bit is set.
- `busy`  out  1  high in any state other than IDLE.
- `div_valid`  out  1  divider start, a one-cycle pulse.
- `div_usigned`, `div_divisor`, `div_dividend`  out  1/W/W  registered operands to the divider.
- `div_quotient`, `div_reminder`  in  W  divider results.
- `div_res_ready`  in  1  divider done, a one-cycle pulse.
- `div_rst_n`  out  1  synchronous active-low reset for the divider.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant rule: if exactly one `req_valid` bit is set, that port is granted. If both are set, the port other than `last_grant` is granted.
  - `req_ready` is combinational and high only for the granted port. It is 0 in every other state.
  - On handshake: latch the operands and `owner`, set `last_grant <= owner`, then go to ISSUE.
- ISSUE: `div_valid=1` for exactly this cycle, then go to WAIT.
- WAIT: hold the operands. On `div_res_ready`, latch `div_quotient`/`div_reminder` into the result registers and go to RESP. `div_res_ready` is ignored in all other states.
- RESP: `rsp_valid[owner]=1` and the result is held stable. On `rsp_ready[owner]`, go to IDLE. `rsp_ready` of the non-owner is ignored.
- The divider's operands stay constant from ISSUE through the last WAIT cycle. This is required because the divider samples operand signs throughout the operation.
- `div_rst_n` is 0 while `rst` is high and for the first `clk` cycle after `rst` deasserts, then 1. This guarantees the divider's synchronous reset sees at least one edge.

## Timing
- Reset values:
  - `req_ready=0`, `rsp_valid=0`, `rsp_quotient=0`, `rsp_reminder=0`, `busy=0`.
  - `div_valid=0`, `div_*` operands 0, `div_rst_n=0`.
  - State IDLE, `last_grant=1`, so port 0 wins the first tie.
- Request accepted at edge E0; `div_valid` is high during cycle E0..E1.
- `rsp_valid` rises the cycle after the edge that samples `div_res_ready`.
- Arbiter overhead is 3 cycles plus the response handshake on top of the divider latency.
- No new request is accepted during the RESP cycle in which `rsp_ready` is sampled. The earliest next accept is the following cycle (IDLE).
- Reset mid-operation (any state): the arbiter immediately returns to IDLE and the captured request and result are discarded. The divider is reset via `div_rst_n`, and no `rsp_valid` is produced for the aborted request.
- Request inputs must stay stable while `req_valid` is high and unaccepted. A request withdrawn before it is granted has no effect.

## Configuration
- `DIV_ZERO_BYPASS_EN` defined:
  - In IDLE, an accepted request with divisor == 0 goes directly to RESP the next cycle.
  - Result: `rsp_quotient` = all ones, `rsp_reminder` = dividend.
  - The divider is not started (`div_valid` stays 0).
- `DIV_ZERO_BYPASS_EN` undefined:
  - A zero divisor is forwarded to the divider unchanged.
  - The divider's normalization loop does not terminate, so requesters must never issue a zero divisor in this build. Behaviour is undefined and is not covered by the bench.

## Test plan
- Single request, unsigned: port 0 issues 100 / 7 with `usigned=1`.
  - Response: `rsp_valid=2'b01`, q=14, r=2.
  - Also check `div_valid` is high for exactly 1 cycle.
- Tie: both ports valid on the first cycle after reset, port 0 with 20/3 and port 1 with 9/4.
  - Port 0 is served first (6, 2), then port 1 (2, 1).
  - A second simultaneous tie grants port 0 again.
- Response backpressure: hold `rsp_ready=0` for 10 cycles.
  - `rsp_valid` and the result stay stable.
  - `req_ready=2'b00` throughout, even with both ports requesting.
- Signed operation: port 1 issues -7 / 2 with `usigned=0`.
  - q = 0xFFFFFFFD, r = 0xFFFFFFFF, and the operands remain constant until `div_res_ready`.
- Reset mid-WAIT: assert `rst` 5 cycles after ISSUE.
  - Immediately: `busy=0`, `rsp_valid=0`, `div_rst_n=0`.
  - After release, the next request completes correctly.
- With `DIV_ZERO_BYPASS_EN` defined: port 0 issues 0x1234 / 0.
  - The next cycle gives `rsp_valid=2'b01`, q=0xFFFFFFFF, r=0x1234, and `div_valid` never pulses.
